cpu_ctl_seq: RTL and testbench
==============================

Name: cpu_ctl_seq

Overview:
Parametrised successor to the fixed CPU reset/ready control in the PET top. It sequences the 6502 reset and ready lines from MCU commands with the following features:
- enforces a minimum reset hold, counted in CPU clocks;
- aligns ready changes to CPU clock boundaries;
- lets NUM_HOLD bus masters stall the CPU;
- adds a counted single-step mode.

It sits between the MCU register/command decoder and the CPU bus pins.

Parameters:
NUM_HOLD, 2, number of independent ready-hold requesters (>=1)
RESET_CYCLES, 2, cpu_en_i strobes for which reset stays asserted after release is requested (>=1)
STEP_CYCLES, 1, un-held cpu_en_i strobes ready stays high per step command (>=1)

Ports:
clk_sys_i  in  1  system clock; all logic on rising edge
reset_n_i  in  1  asynchronous, active-low reset
cpu_en_i  in  1  one-clk_sys_i strobe marking each CPU clock boundary
cmd_valid_i  in  1  command strobe, sampled every clk_sys_i
cmd_reset_i  in  1  requested CPU reset (1 = assert)
cmd_ready_i  in  1  requested CPU ready (1 = run)
cmd_step_i  in  1  single-step request
hold_i  in  NUM_HOLD  per-master hold; any bit high forces ready low
cpu_reset_o  out  1  CPU reset, active high (registered)
cpu_ready_o  out  1  CPU RDY (registered)
state_o  out  3  current state encoding (status readback)
busy_o  out  1  high in RESET_HOLD or STEP

Behaviour:
- Async reset (reset_n_i low, any time, including mid-step or mid-hold):
  - state=RESET, cpu_reset_o=1, cpu_ready_o=0;
  - ready_req=0, hold counter=0, step counter=0;
  - takes effect immediately, without waiting for a clock edge.
- States: RESET, RESET_HOLD, HALTED, RUNNING, STEP.
- Command latency: a command accepted at edge N changes state at edge N.
- ready_req updates on every cmd_valid_i, in every state.
- Reset commands:
  - cmd_reset_i=1 from any state goes to RESET; counters are cleared.
  - In RESET, cmd_reset_i=1 is a no-op apart from the ready_req update.
  - Reset wins over step when both are presented together.
- RESET:
  - cpu_reset_o=1 and cpu_ready_o=0 are forced on the next edge; no cpu_en_i alignment.
  - cmd_valid_i with cmd_reset_i=0 goes to RESET_HOLD with the counter at 0.
- RESET_HOLD:
  - cpu_reset_o stays 1; the counter increments on each cpu_en_i.
  - On the cpu_en_i edge where the counter reaches RESET_CYCLES, cpu_reset_o goes to 0.
  - The state then becomes RUNNING if ready_req=1, else HALTED.
  - Counter width is $clog2(RESET_CYCLES+1); the counter saturates and never wraps.
  - cmd_reset_i=0 during hold updates ready_req only and does not restart the count.
- HALTED / RUNNING:
  - A command with cmd_reset_i=0 and cmd_step_i=0 selects RUNNING if cmd_ready_i=1, else HALTED.
- STEP:
  - Entered from HALTED when cmd_step_i=1 and cmd_reset_i=0 (cmd_ready_i ignored); step counter cleared.
  - cmd_step_i is ignored in RUNNING, RESET and RESET_HOLD.
  - The counter increments on cpu_en_i edges where cpu_ready_o=1 and ~|hold_i. Held cycles do not count.
  - On reaching STEP_CYCLES, the state returns to HALTED (or RUNNING if ready_req was set during the step).
  - A non-reset command during STEP only updates ready_req.
- cpu_ready_o:
  - Updates only on edges where cpu_en_i=1, so the CPU never sees a mid-cycle glitch.
  - next value = (state in {RUNNING, STEP}) and not(|hold_i) and not cpu_reset_o.
  - First high is therefore at least one cpu_en_i after reset release.
  - The 0 forced by RESET overrides the cpu_en_i alignment.
- hold_i:
  - Sampled at cpu_en_i edges, so holds raised between strobes take effect at the next strobe.
  - A hold does not change state.
- busy_o = state in {RESET_HOLD, STEP}, combinational from the state register.
- Simultaneous cpu_en_i and cmd_valid_i on the same edge:
  - The command's state change and the cpu_en_i count apply together.
  - cpu_ready_o uses the post-command state.

Decomposition:
- Package cpu_ctl_pkg holds:
  - cpu_ctl_state_t, 3-bit enum (RESET=0, RESET_HOLD=1, HALTED=2, RUNNING=3, STEP=4);
  - width helper constants.
- Single module; no sub-module is needed.
- The two counters are a shared saturating-counter pattern, written inline.

Test Plan:
- Power-on reset, then 4 cpu_en_i strobes with no command -> cpu_reset_o=1, cpu_ready_o=0, state_o=0.
- Command (reset=0, ready=1) with RESET_CYCLES=2 -> cpu_reset_o falls on the 2nd cpu_en_i. cpu_ready_o rises on the 3rd cpu_en_i and never earlier; state_o=3.
- Sequence (1,1), (1,0), (0,1) issued between strobes:
  - reset reasserts on the edge after the first command;
  - cpu_ready_o drops immediately, with no cpu_en_i wait;
  - the hold count restarts; ready returns 3 strobes after the last command.
- From HALTED, step with STEP_CYCLES=1, hold_i=2'b01 for the first 2 strobes -> cpu_ready_o stays 0 for 2 strobes. It is then high for exactly 1 strobe; state returns to 2; busy_o is high throughout.
- RUNNING, toggle hold_i[1] between strobes -> cpu_ready_o changes only on cpu_en_i edges and never on other edges.
- Drop reset_n_i mid-STEP and mid-RESET_HOLD -> outputs return to reset values with no clock. After release, state_o=0 and ready_req=0.

Source files
------------

// File: rtl/cpu_ctl_pkg.sv
// Shared types and width helpers for the 6502 reset/ready sequencer.
// Imported by cpu_ctl_seq and any status decoder reading state_o.
package cpu_ctl_pkg;

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_RESET_HOLD = 3'd1,
        ST_HALTED     = 3'd2,
        ST_RUNNING    = 3'd3,
        ST_STEP       = 3'd4
    } cpu_ctl_state_t;

    localparam int STATE_W = 3;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cpu_ctl_seq.sv
// Sequences 6502 reset/RDY from MCU commands: counted reset hold,
// cpu_en-aligned RDY, bus-master stalls and counted single-step.
module cpu_ctl_seq
    import cpu_ctl_pkg::*;
#(
    parameter int NUM_HOLD     = 2,
    parameter int RESET_CYCLES = 2,
    parameter int STEP_CYCLES  = 1
) (
    input  logic                clk_sys_i,
    input  logic                reset_n_i,
    input  logic                cpu_en_i,
    input  logic                cmd_valid_i,
    input  logic                cmd_reset_i,
    input  logic                cmd_ready_i,
    input  logic                cmd_step_i,
    input  logic [NUM_HOLD-1:0] hold_i,
    output logic                cpu_reset_o,
    output logic                cpu_ready_o,
    output logic [STATE_W-1:0]  state_o,
    output logic                busy_o
);

    localparam int HOLD_W = cnt_width(RESET_CYCLES);
    localparam int STEP_W = cnt_width(STEP_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RESET_CYCLES);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_CYCLES);

    cpu_ctl_state_t    state, state_nx;
    logic              ready_req, req_nx;
    logic [HOLD_W-1:0] hold_cnt, hcnt_nx, hold_sat;
    logic [STEP_W-1:0] step_cnt, scnt_nx, step_sat;
    logic              rst_nx, rdy_nx, held;

    assign held     = |hold_i;
    assign hold_sat = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
    assign step_sat = (step_cnt == STEP_MAX) ? step_cnt : step_cnt + 1'b1;

    always_comb begin
        req_nx   = cmd_valid_i ? cmd_ready_i : ready_req;
        state_nx = state;
        hcnt_nx  = hold_cnt;
        scnt_nx  = step_cnt;
        rst_nx   = cpu_reset_o;
        if (cmd_valid_i && cmd_reset_i) begin
            state_nx = ST_RESET;
            hcnt_nx  = '0;
            scnt_nx  = '0;
            rst_nx   = 1'b1;
        end else begin
            unique case (state)
                ST_RESET: begin
                    rst_nx = 1'b1;
                    if (cmd_valid_i) begin
                        state_nx = ST_RESET_HOLD;
                        hcnt_nx  = '0;
                    end
                end
                ST_RESET_HOLD: begin
                    if (cpu_en_i) begin
                        hcnt_nx = hold_sat;
                        if (hold_sat == HOLD_MAX) begin
                            rst_nx   = 1'b0;
                            state_nx = req_nx ? ST_RUNNING : ST_HALTED;
                        end
                    end
                end
                ST_HALTED: begin
                    if (cmd_valid_i) begin
                        if (cmd_step_i) begin
                            state_nx = ST_STEP;
                            scnt_nx  = '0;
                        end else begin
                            state_nx = cmd_ready_i ? ST_RUNNING : ST_HALTED;
                        end
                    end
                end
                ST_RUNNING: begin
                    if (cmd_valid_i)
                        state_nx = cmd_ready_i ? ST_RUNNING : ST_HALTED;
                end
                ST_STEP: begin
                    // only cycles the CPU actually executed count as steps
                    if (cpu_en_i && cpu_ready_o && !held) begin
                        scnt_nx = step_sat;
                        if (step_sat == STEP_MAX)
                            state_nx = req_nx ? ST_RUNNING : ST_HALTED;
                    end
                end
                default: begin
                    state_nx = ST_RESET;
                    rst_nx   = 1'b1;
                end
            endcase
        end

        rdy_nx = cpu_ready_o;
        if (state_nx == ST_RESET)
            rdy_nx = 1'b0;
        else if (cpu_en_i)
            rdy_nx = (state_nx == ST_RUNNING || state_nx == ST_STEP)
                     && !held && !cpu_reset_o;
    end

    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= ST_RESET;
            ready_req   <= 1'b0;
            hold_cnt    <= '0;
            step_cnt    <= '0;
            cpu_reset_o <= 1'b1;
            cpu_ready_o <= 1'b0;
        end else begin
            state       <= state_nx;
            ready_req   <= req_nx;
            hold_cnt    <= hcnt_nx;
            step_cnt    <= scnt_nx;
            cpu_reset_o <= rst_nx;
            cpu_ready_o <= rdy_nx;
        end
    end

    assign state_o = state;
    assign busy_o  = (state == ST_RESET_HOLD) || (state == ST_STEP);

endmodule

// File: tb/tb_cpu_ctl_seq.sv
// Directed bench for cpu_ctl_seq with default parameters
// (NUM_HOLD=2, RESET_CYCLES=2, STEP_CYCLES=1).
module tb_cpu_ctl_seq;

    logic       clk_sys_i = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       cpu_en_i = 1'b0;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_reset_i = 1'b0;
    logic       cmd_ready_i = 1'b0;
    logic       cmd_step_i = 1'b0;
    logic [1:0] hold_i = 2'b00;
    logic       cpu_reset_o;
    logic       cpu_ready_o;
    logic [2:0] state_o;
    logic       busy_o;

    int checks = 0;
    int failures = 0;

    cpu_ctl_seq #(
        .NUM_HOLD(2),
        .RESET_CYCLES(2),
        .STEP_CYCLES(1)
    ) dut (
        .clk_sys_i(clk_sys_i),
        .reset_n_i(reset_n_i),
        .cpu_en_i(cpu_en_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_reset_i(cmd_reset_i),
        .cmd_ready_i(cmd_ready_i),
        .cmd_step_i(cmd_step_i),
        .hold_i(hold_i),
        .cpu_reset_o(cpu_reset_o),
        .cpu_ready_o(cpu_ready_o),
        .state_o(state_o),
        .busy_o(busy_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    task automatic tick();
        @(posedge clk_sys_i);
        #1;
    endtask

    task automatic strobe();
        cpu_en_i = 1'b1;
        tick();
        cpu_en_i = 1'b0;
    endtask

    task automatic cmd(input logic r, input logic y, input logic s);
        cmd_valid_i = 1'b1;
        cmd_reset_i = r;
        cmd_ready_i = y;
        cmd_step_i  = s;
        tick();
        cmd_valid_i = 1'b0;
        cmd_reset_i = 1'b0;
        cmd_ready_i = 1'b0;
        cmd_step_i  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        tick();
        tick();
        reset_n_i = 1'b1;
        tick();
        checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL por_state got=%0d exp=0", state_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL por_busy got=%0b exp=0", busy_o); end
        for (int i = 0; i < 4; i++) begin
            tick();
            strobe();
            checks++; if (cpu_reset_o !== 1'b1) begin failures++; $display("FAIL por_rst[%0d] got=%0b exp=1", i, cpu_reset_o); end
            checks++; if (cpu_ready_o !== 1'b0) begin failures++; $display("FAIL por_rdy[%0d] got=%0b exp=0", i, cpu_ready_o); end
            checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL por_st[%0d] got=%0d exp=0", i, state_o); end
        end
    endtask

    task automatic test_release();
        cmd(1'b0, 1'b1, 1'b0);
        checks++; if (state_o !== 3'd1) begin failures++; $display("FAIL rel_st got=%0d exp=1", state_o); end
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL rel_busy got=%0b exp=1", busy_o); end
        tick();
        strobe();
        checks++; if (cpu_reset_o !== 1'b1) begin failures++; $display("FAIL rel_rst1 got=%0b exp=1", cpu_reset_o); end
        checks++; if (state_o !== 3'd1) begin failures++; $display("FAIL rel_st1 got=%0d exp=1", state_o); end
        tick();
        strobe();
        checks++; if (cpu_reset_o !== 1'b0) begin failures++; $display("FAIL rel_rst2 got=%0b exp=0", cpu_reset_o); end
        checks++; if (cpu_ready_o !== 1'b0) begin failures++; $display("FAIL rel_rdy2 got=%0b exp=0", cpu_ready_o); end
        checks++; if (state_o !== 3'd3) begin failures++; $display("FAIL rel_st2 got=%0d exp=3", state_o); end
        tick();
        checks++; if (cpu_ready_o !== 1'b0) begin failures++; $display("FAIL rel_rdy_gap got=%0b exp=0", cpu_ready_o); end
        strobe();
        checks++; if (cpu_ready_o !== 1'b1) begin failures++; $display("FAIL rel_rdy3 got=%0b exp=1", cpu_ready_o); end
    endtask

    task automatic test_rereset();
        cmd(1'b1, 1'b1, 1'b0);
        checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL rr_st got=%0d exp=0", state_o); end
        checks++; if (cpu_reset_o !== 1'b1) begin failures++; $display("FAIL rr_rst got=%0b exp=1", cpu_reset_o); end
        checks++; if (cpu_ready_o !== 1'b0) begin failures++; $display("FAIL rr_rdy got=%0b exp=0", cpu_ready_o); end
        cmd(1'b1, 1'b0, 1'b0);
        checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL rr_st2 got=%0d exp=0", state_o); end
        cmd(1'b0, 1'b1, 1'b0);
        checks++; if (state_o !== 3'd1) begin failures++; $display("FAIL rr_st3 got=%0d exp=1", state_o); end
        strobe();
        tick();
        checks++; if (cpu_reset_o !== 1'b1) begin failures++; $display("FAIL rr_rst1 got=%0b exp=1", cpu_reset_o); end
        strobe();
        checks++; if (cpu_reset_o !== 1'b0) begin failures++; $display("FAIL rr_rst2 got=%0b exp=0", cpu_reset_o); end
        checks++; if (cpu_ready_o !== 1'b0) begin failures++; $display("FAIL rr_rdy2 got=%0b exp=0", cpu_ready_o); end
        strobe();
        checks++; if (cpu_ready_o !== 1'b1) begin failures++; $display("FAIL rr_rdy3 got=%0b exp=1", cpu_ready_o); end
        checks++; if (state_o !== 3'd3) begin failures++; $display("FAIL rr_st4 got=%0d exp=3", state_o); end
    endtask

    task automatic test_step();
        cmd(1'b0, 1'b0, 1'b0);
        checks++; if (state_o !== 3'd2) begin failures++; $display("FAIL st_halt got=%0d exp=2", state_o); end
        checks++; if (cpu_ready_o !== 1'b1) begin failures++; $display("FAIL st_rdy_noalign got=%0b exp=1", cpu_ready_o); end
        strobe();
        checks++; if (cpu_ready_o !== 1'b0) begin failures++; $display("FAIL st_rdy_halt got=%0b exp=0", cpu_ready_o); end
        hold_i = 2'b01;
        cmd(1'b0, 1'b0, 1'b1);
        checks++; if (state_o !== 3'd4) begin failures++; $display("FAIL st_enter got=%0d exp=4", state_o); end
        for (int i = 0; i < 2; i++) begin
            strobe();
            checks++; if (cpu_ready_o !== 1'b0) begin failures++; $display("FAIL st_held[%0d] got=%0b exp=0", i, cpu_ready_o); end
            checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL st_busy[%0d] got=%0b exp=1", i, busy_o); end
            tick();
        end
        hold_i = 2'b00;
        strobe();
        checks++; if (cpu_ready_o !== 1'b1) begin failures++; $display("FAIL st_run got=%0b exp=1", cpu_ready_o); end
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL st_busy_run got=%0b exp=1", busy_o); end
        tick();
        strobe();
        checks++; if (cpu_ready_o !== 1'b0) begin failures++; $display("FAIL st_done_rdy got=%0b exp=0", cpu_ready_o); end
        checks++; if (state_o !== 3'd2) begin failures++; $display("FAIL st_done_st got=%0d exp=2", state_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL st_done_busy got=%0b exp=0", busy_o); end
    endtask

    task automatic test_hold_toggle();
        cmd(1'b0, 1'b1, 1'b0);
        strobe();
        checks++; if (cpu_ready_o !== 1'b1) begin failures++; $display("FAIL ht_run got=%0b exp=1", cpu_ready_o); end
        hold_i = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (cpu_ready_o !== 1'b1) begin failures++; $display("FAIL ht_noedge[%0d] got=%0b exp=1", i, cpu_ready_o); end
        end
        strobe();
        checks++; if (cpu_ready_o !== 1'b0) begin failures++; $display("FAIL ht_held got=%0b exp=0", cpu_ready_o); end
        checks++; if (state_o !== 3'd3) begin failures++; $display("FAIL ht_st got=%0d exp=3", state_o); end
        hold_i = 2'b00;
        tick();
        tick();
        checks++; if (cpu_ready_o !== 1'b0) begin failures++; $display("FAIL ht_rel_wait got=%0b exp=0", cpu_ready_o); end
        strobe();
        checks++; if (cpu_ready_o !== 1'b1) begin failures++; $display("FAIL ht_rel got=%0b exp=1", cpu_ready_o); end
    endtask

    task automatic test_back_to_back();
        cpu_en_i = 1'b1;
        cmd(1'b0, 1'b0, 1'b0);
        cpu_en_i = 1'b0;
        checks++; if (state_o !== 3'd2) begin failures++; $display("FAIL bb_st got=%0d exp=2", state_o); end
        checks++; if (cpu_ready_o !== 1'b0) begin failures++; $display("FAIL bb_rdy got=%0b exp=0", cpu_ready_o); end
        cmd(1'b0, 1'b1, 1'b0);
        strobe();
        cmd(1'b0, 1'b1, 1'b1);
        checks++; if (state_o !== 3'd3) begin failures++; $display("FAIL bb_step_ign got=%0d exp=3", state_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL bb_busy got=%0b exp=0", busy_o); end
    endtask

    task automatic test_async();
        cmd(1'b0, 1'b0, 1'b0);
        strobe();
        cmd(1'b0, 1'b0, 1'b1);
        strobe();
        checks++; if (cpu_ready_o !== 1'b1) begin failures++; $display("FAIL as_step_rdy got=%0b exp=1", cpu_ready_o); end
        #2 reset_n_i = 1'b0;
        #1;
        checks++; if (cpu_reset_o !== 1'b1) begin failures++; $display("FAIL as_step_rst got=%0b exp=1", cpu_reset_o); end
        checks++; if (cpu_ready_o !== 1'b0) begin failures++; $display("FAIL as_step_rdy0 got=%0b exp=0", cpu_ready_o); end
        checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL as_step_st got=%0d exp=0", state_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL as_step_busy got=%0b exp=0", busy_o); end
        #1 reset_n_i = 1'b1;
        strobe();
        checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL as_post_st got=%0d exp=0", state_o); end
        cmd(1'b0, 1'b1, 1'b0);
        strobe();
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL as_hold_busy got=%0b exp=1", busy_o); end
        #2 reset_n_i = 1'b0;
        #1;
        checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL as_hold_st got=%0d exp=0", state_o); end
        checks++; if (cpu_reset_o !== 1'b1) begin failures++; $display("FAIL as_hold_rst got=%0b exp=1", cpu_reset_o); end
        #1 reset_n_i = 1'b1;
        for (int i = 0; i < 3; i++) strobe();
        checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL as_end_st got=%0d exp=0", state_o); end
        checks++; if (cpu_reset_o !== 1'b1) begin failures++; $display("FAIL as_end_rst got=%0b exp=1", cpu_reset_o); end
        checks++; if (cpu_ready_o !== 1'b0) begin failures++; $display("FAIL as_end_rdy got=%0b exp=0", cpu_ready_o); end
    endtask

    initial begin
        test_reset();
        test_release();
        test_rereset();
        test_step();
        test_hold_toggle();
        test_back_to_back();
        test_async();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
